// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read mode.
// Latency: standard mode returns a word one cycle after rd_en_i; FWFT exposes the head word right after the edge that wrote it.
// Backpressure: writes to a full FIFO and reads from an empty FIFO are dropped and signalled by a one-cycle overflow/underflow pulse.
//
// Ports:
//   clk_i, rst_i          clock; asynchronous active-high reset
//   flush_i               synchronous clear of contents, wins over wr_en_i/rd_en_i
//   din_i, wr_en_i        write data and write request
//   rd_en_i               read request (standard) / pop (FWFT)
//   dout_o, valid_o       read data and its qualifier
//   full_o, empty_o       count == DEPTH / count == 0
//   almost_full_o         count >= AFULL_THRESH
//   almost_empty_o        count <= AEMPTY_THRESH
//   overflow_o            one-cycle pulse: write rejected
//   underflow_o           one-cycle pulse: read rejected
//   data_count_o          words stored, 0..DEPTH
module param_sync_fifo #(
  parameter int unsigned DATA_W        = 15,
  parameter int unsigned ADDR_W        = 11,
  parameter int unsigned FWFT          = 0,
  parameter int unsigned AFULL_THRESH  = 2040,
  parameter int unsigned AEMPTY_THRESH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              valid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic [ADDR_W:0]   data_count_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

  if (!((AEMPTY_THRESH < AFULL_THRESH) && (AFULL_THRESH <= DEPTH))) begin : g_bad_params
    $error("param_sync_fifo: thresholds must satisfy AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
  end

  // Storage is never reset; pointers and count define what is valid.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              full_q,   full_d;
  logic              empty_q,  empty_d;
  logic              afull_q,  afull_d;
  logic              aempty_q, aempty_d;
  logic              ovf_q,    ovf_d;
  logic              udf_q,    udf_d;

  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] head;

  // Accept decisions use the registered flags, so a simultaneous read
  // cannot make room for a write into a full FIFO (and vice versa).
  assign wr_ok = wr_en_i & ~full_q  & ~flush_i;
  assign rd_ok = rd_en_i & ~empty_q & ~flush_i;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    // Flags are registered but computed from the next count so they
    // line up with data_count_o on the same edge.
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
    ovf_d    = wr_en_i & full_q  & ~flush_i;
    udf_d    = rd_en_i & empty_q & ~flush_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= din_i;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is shown combinationally; it is meaningful only with valid_o.
    assign dout_o  = head;
    assign valid_o = ~empty_q;
  end else begin : g_std
    logic [DATA_W-1:0] dout_q,  dout_d;
    logic              valid_q, valid_d;

    // dout holds across rejected reads and flushes; valid is a one-cycle strobe.
    assign dout_d  = rd_ok ? head : dout_q;
    assign valid_d = rd_ok;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        dout_q  <= dout_d;
        valid_q <= valid_d;
      end
    end

    assign dout_o  = dout_q;
    assign valid_o = valid_q;
  end

  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;
  assign data_count_o   = count_q;

endmodule
